// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data-memory unit: stackControl encodings,
// FSM state type and default bus widths.
package data_mem_unit_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    SC_IMM   = 3'd0,
    SC_UPPER = 3'd1,
    SC_MEM   = 3'd2,
    SC_IN    = 3'd4
  } stack_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_IN_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/data_mem_unit_if.sv
// Request, RAM, input-port and result signals of the data-memory unit.
// master = surrounding core/environment, slave = data_mem_unit.
interface data_mem_unit_if
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req;
  logic [15:0]       inst;
  logic [2:0]        stackControl;
  logic              MemWrite;
  logic [DATA_W-1:0] memWriteData;

  logic [DATA_W-1:0] getinData;
  logic              getinValid;
  logic              getinReady;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] newPC;
  logic [DATA_W-1:0] stackWriteData;
  logic              stackWriteValid;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req, inst, stackControl, MemWrite, memWriteData,
    output getinData, getinValid, mem_rdata,
    input  getinReady, mem_addr, mem_we, mem_wdata,
    input  newPC, stackWriteData, stackWriteValid, busy, done, err
  );

  modport slave (
    input  req, inst, stackControl, MemWrite, memWriteData,
    input  getinData, getinValid, mem_rdata,
    output getinReady, mem_addr, mem_we, mem_wdata,
    output newPC, stackWriteData, stackWriteValid, busy, done, err
  );

endinterface

// File: rtl/data_mem_unit_imm_former.sv
// Immediate formation: sign-extended 12-bit immediate, or the 4-bit
// upper immediate placed in the top nibble of the word.
module imm_former #(
  parameter int DATA_W = 16
) (
  input  logic [11:0]       imm12,
  input  logic              upper,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    imm = {{(DATA_W-12){imm12[11]}}, imm12};
    if (upper) imm = {imm12[3:0], {(DATA_W-4){1'b0}}};
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory unit: immediates, RAM load/store and input-port reads into the stack.
// Optional store-to-load forwarding register enabled by macro DMEM_STORE_FWD_EN.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic            CLK,
  input  logic            reset,
  data_mem_unit_if.slave  bus
);

  state_e            state;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] imm_val;
  logic [ADDR_W-1:0] req_addr;
  logic              sel_upper;

  assign req_addr       = bus.inst[ADDR_W-1:0];
  assign sel_upper      = (bus.stackControl == SC_UPPER);
  assign bus.newPC      = {{(DATA_W-13){1'b0}}, bus.inst[11:0], 1'b0};
  assign bus.busy       = (state != ST_IDLE);
  assign bus.getinReady = (state == ST_IN_WAIT);

  imm_former #(.DATA_W(DATA_W)) u_imm_former (
    .imm12 (bus.inst[11:0]),
    .upper (sel_upper),
    .imm   (imm_val)
  );

`ifdef DMEM_STORE_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else if (state == ST_IDLE && bus.req && bus.stackControl == SC_MEM && bus.MemWrite) begin
      fwd_valid <= 1'b1;
      fwd_addr  <= req_addr;
      fwd_data  <= bus.memWriteData;
    end
  end
`endif

  // mem_addr is the RAM's address stage, so the read data is due MEM_LAT
  // edges after the request edge; lat_cnt starts at 1 on that edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state               <= ST_IDLE;
      lat_cnt             <= '0;
      bus.stackWriteData  <= '0;
      bus.stackWriteValid <= 1'b0;
      bus.done            <= 1'b0;
      bus.err             <= 1'b0;
      bus.mem_we          <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
    end else begin
      bus.stackWriteValid <= 1'b0;
      bus.done            <= 1'b0;
      bus.err             <= 1'b0;
      bus.mem_we          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            case (bus.stackControl)
              SC_IMM, SC_UPPER: begin
                bus.stackWriteData  <= imm_val;
                bus.stackWriteValid <= 1'b1;
                bus.done            <= 1'b1;
                state               <= ST_DONE;
              end
              SC_MEM: begin
                if (bus.MemWrite) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= req_addr;
                  bus.mem_wdata <= bus.memWriteData;
                  bus.done      <= 1'b1;
                  state         <= ST_DONE;
                end
`ifdef DMEM_STORE_FWD_EN
                else if (fwd_valid && fwd_addr == req_addr) begin
                  bus.stackWriteData  <= fwd_data;
                  bus.stackWriteValid <= 1'b1;
                  bus.done            <= 1'b1;
                  state               <= ST_DONE;
                end
`endif
                else begin
                  bus.mem_addr <= req_addr;
                  lat_cnt      <= 3'd1;
                  state        <= ST_RD_WAIT;
                end
              end
              SC_IN: state <= ST_IN_WAIT;
              default: begin
                bus.stackWriteData <= '0;
                bus.err            <= 1'b1;
                bus.done           <= 1'b1;
                state              <= ST_DONE;
              end
            endcase
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == 3'(MEM_LAT)) begin
            bus.stackWriteData  <= bus.mem_rdata;
            bus.stackWriteValid <= 1'b1;
            bus.done            <= 1'b1;
            lat_cnt             <= '0;
            state               <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_IN_WAIT: begin
          if (bus.getinValid) begin
            bus.stackWriteData  <= bus.getinData;
            bus.stackWriteValid <= 1'b1;
            bus.done            <= 1'b1;
            state               <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit (MEM_LAT=3) with a
// behavioural RAM whose address stage is the unit's mem_addr register.
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int LAT = 3;
`ifdef DMEM_STORE_FWD_EN
  localparam int FWD_LAT = 1;
`else
  localparam int FWD_LAT = LAT + 1;
`endif

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  data_mem_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:LAT-2];

  always @(posedge CLK) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= ram[bus.mem_addr];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign bus.mem_rdata = rd_pipe[LAT-2];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] sc, input logic mw, input logic [15:0] ins,
                       input logic [15:0] wd);
    bus.stackControl = sc;
    bus.MemWrite     = mw;
    bus.inst         = ins;
    bus.memWriteData = wd;
    bus.req          = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    tick;
    bus.req = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  int lat;
  int cnt;

  initial begin
    bus.req = 1'b0; bus.inst = '0; bus.stackControl = '0; bus.MemWrite = 1'b0;
    bus.memWriteData = '0; bus.getinData = '0; bus.getinValid = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_data",  32'(bus.stackWriteData), 32'h0);
    chk("rst_valid", 32'(bus.stackWriteValid), 32'h0);
    chk("rst_done",  32'(bus.done), 32'h0);
    chk("rst_err",   32'(bus.err), 32'h0);
    chk("rst_we",    32'(bus.mem_we), 32'h0);
    chk("rst_addr",  32'(bus.mem_addr), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_ready", 32'(bus.getinReady), 32'h0);
    #2 reset = 1'b1;
    tick;

    // Sign-extended immediate, plus newPC
    issue(3'd0, 1'b0, 16'h0FFF, 16'h0);
    #1 chk("newpc", 32'(bus.newPC), 32'h1FFE);
    wait_done(lat);
    chk("imm_lat",   lat, 1);
    chk("imm_data",  32'(bus.stackWriteData), 32'hFFFF);
    chk("imm_valid", 32'(bus.stackWriteValid), 32'h1);
    chk("imm_busy",  32'(bus.busy), 32'h1);
    tick;
    chk("imm_valid_drop", 32'(bus.stackWriteValid), 32'h0);
    chk("imm_hold",  32'(bus.stackWriteData), 32'hFFFF);
    chk("imm_idle",  32'(bus.busy), 32'h0);

    issue(3'd0, 1'b0, 16'h07FF, 16'h0);
    wait_done(lat); tick;
    chk("imm_pos", 32'(bus.stackWriteData), 32'h07FF);
    issue(3'd0, 1'b0, 16'hF800, 16'h0);
    wait_done(lat); tick;
    chk("imm_neg", 32'(bus.stackWriteData), 32'hF800);
    issue(3'd1, 1'b0, 16'h0FFA, 16'h0);
    wait_done(lat);
    chk("upper_data",  32'(bus.stackWriteData), 32'hA000);
    chk("upper_valid", 32'(bus.stackWriteValid), 32'h1);
    tick;

    // Stores
    issue(3'd2, 1'b1, 16'h00A0, 16'h5A5A);
    wait_done(lat); tick;
    issue(3'd2, 1'b1, 16'h0005, 16'hBEEF);
    wait_done(lat);
    chk("st_lat",   lat, 1);
    chk("st_we",    32'(bus.mem_we), 32'h1);
    chk("st_addr",  32'(bus.mem_addr), 32'h005);
    chk("st_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    chk("st_valid", 32'(bus.stackWriteValid), 32'h0);
    chk("st_hold",  32'(bus.stackWriteData), 32'hA000);
    tick;
    chk("st_we_drop", 32'(bus.mem_we), 32'h0);

    // Load of the just-stored address
    issue(3'd2, 1'b0, 16'h0005, 16'h0);
    wait_done(lat);
    chk("ld5_lat",   lat, FWD_LAT);
    chk("ld5_data",  32'(bus.stackWriteData), 32'hBEEF);
    chk("ld5_valid", 32'(bus.stackWriteValid), 32'h1);
    chk("ld5_we",    32'(bus.mem_we), 32'h0);
    tick;

    // Load from RAM with a request injected while busy
    issue(3'd2, 1'b0, 16'h00A0, 16'h0);
    tick;
    chk("ldA_busy", 32'(bus.busy), 32'h1);
    issue(3'd0, 1'b0, 16'h0123, 16'h0);
    lat = 1;
    wait_done(cnt);
    lat += cnt;
    chk("ldA_lat",  lat, LAT + 1);
    chk("ldA_data", 32'(bus.stackWriteData), 32'h5A5A);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (bus.done) cnt++;
    end
    chk("busy_req_dropped", cnt, 0);
    chk("busy_req_hold",    32'(bus.stackWriteData), 32'h5A5A);

    // Illegal selects
    issue(3'd6, 1'b0, 16'h0123, 16'h0);
    wait_done(lat);
    chk("ill6_lat",   lat, 1);
    chk("ill6_err",   32'(bus.err), 32'h1);
    chk("ill6_valid", 32'(bus.stackWriteValid), 32'h0);
    chk("ill6_data",  32'(bus.stackWriteData), 32'h0);
    tick;
    chk("ill6_err_drop", 32'(bus.err), 32'h0);
    issue(3'd3, 1'b0, 16'h0001, 16'h0);
    wait_done(lat);
    chk("ill3_err", 32'(bus.err), 32'h1);
    tick;

    // Input port: getinValid low for five busy cycles
    bus.getinValid = 1'b0;
    issue(3'd4, 1'b0, 16'h0, 16'h0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      bus.req = 1'b0;
      if (bus.busy && bus.getinReady && !bus.done) cnt++;
    end
    chk("in_wait_cycles", cnt, 5);
    bus.getinValid = 1'b1;
    bus.getinData  = 16'h1234;
    tick;
    bus.getinValid = 1'b0;
    chk("in_done",  32'(bus.done), 32'h1);
    chk("in_data",  32'(bus.stackWriteData), 32'h1234);
    chk("in_valid", 32'(bus.stackWriteValid), 32'h1);
    chk("in_ready_done", 32'(bus.getinReady), 32'h0);
    tick;
    chk("in_idle", 32'(bus.busy), 32'h0);

    // Reset in RD_WAIT
    issue(3'd2, 1'b0, 16'h00A0, 16'h0);
    tick;
    bus.req = 1'b0;
    tick;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(bus.busy), 32'h0);
    chk("mid_rst_data",  32'(bus.stackWriteData), 32'h0);
    chk("mid_rst_valid", 32'(bus.stackWriteValid), 32'h0);
    chk("mid_rst_done",  32'(bus.done), 32'h0);
    chk("mid_rst_addr",  32'(bus.mem_addr), 32'h0);
    chk("mid_rst_wdata", 32'(bus.mem_wdata), 32'h0);
    tick; tick;
    #2 reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.done || bus.busy) cnt++;
    end
    chk("no_done_after_reset", cnt, 0);

    issue(3'd1, 1'b0, 16'h0005, 16'h0);
    wait_done(lat);
    chk("post_rst_lat",  lat, 1);
    chk("post_rst_data", 32'(bus.stackWriteData), 32'h5000);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DATA_W, default 16: stack/memory word width; legal values are 16 and 32.
REQ-002 Parameter ADDR_W, default 12: data-memory word-address width; must satisfy ADDR_W+1 <= DATA_W.
REQ-003 Parameter MEM_LAT, default 1: data-memory read latency in cycles; legal range 1..4.
REQ-004 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  1  one-cycle operation request; sampled only when busy=0.
REQ-007 inst  in  16  instruction; inst[11:0] holds the immediate/address and inst[3:0] the upper-immediate nibble.
REQ-008 stackControl  in  3  source select: 0 = sign-extended imm, 1 = upper imm, 2 = memory, 4 = input port.
REQ-009 MemWrite  in  1  with stackControl=2, selects a store instead of a load.
REQ-010 memWriteData  in  DATA_W  store data.
REQ-011 getinData  in  DATA_W  / getinValid  in  1 / getinReady  out  1: input-port handshake.
REQ-012 mem_addr  out  ADDR_W / mem_we  out  1 / mem_wdata  out  DATA_W / mem_rdata  in  DATA_W: synchronous RAM port.
REQ-013 newPC  out  DATA_W  combinational jump target: zero-extended {inst[11:0],1'b0}.
REQ-014 stackWriteData  out  DATA_W / stackWriteValid  out  1: registered result, valid for exactly one cycle.
REQ-015 busy  out  1 / done  out  1 / err  out  1: stall indication, completion pulse, and illegal-select pulse.

Function
REQ-016 The FSM states shall be IDLE, RD_WAIT, IN_WAIT and DONE.
REQ-017 In IDLE, req with stackControl 0 or 1 shall go to DONE; stackWriteData shall be sign-extended inst[11:0] for 0, or inst[3:0] in bits [DATA_W-1:DATA_W-4] with zeros below for 1.
REQ-018 In IDLE, req with stackControl=2 and MemWrite=1 shall drive mem_we=1, mem_addr=inst[ADDR_W-1:0] and mem_wdata=memWriteData for one cycle, then go to DONE with stackWriteValid=0.
REQ-019 In IDLE, req with stackControl=2 and MemWrite=0 shall issue a read at inst[ADDR_W-1:0] and enter RD_WAIT; after MEM_LAT cycles it shall capture mem_rdata and go to DONE.
REQ-020 In IDLE, req with stackControl=4 shall enter IN_WAIT; getinReady shall be 1 only in IN_WAIT; the cycle in which getinValid=1 captures getinData and goes to DONE.
REQ-021 Illegal stackControl values (3, 5, 6, 7) shall go to DONE with stackWriteData=0, stackWriteValid=0 and err=1 for one cycle.
REQ-022 DONE shall last one cycle and pulse done; stackWriteValid shall be 1 except for stores and illegal selects; the next state is IDLE.
REQ-023 busy shall be 1 in every state except IDLE; req while busy shall be ignored and not queued.
REQ-024 Latency from req to done shall be 1 cycle for immediates and stores, MEM_LAT+1 cycles for loads, and (wait cycles)+1 for input.
REQ-025 stackWriteData shall hold its last value between results; mem_we shall be 0 outside the store-issue cycle.

Reset
REQ-026 Assertion of reset, including mid-operation, shall force IDLE and zero stackWriteData, stackWriteValid, done, err, mem_we, mem_addr and mem_wdata, and the latency counter.
REQ-027 An operation interrupted by reset shall be dropped, with no done pulse after reset deasserts.

Configuration
REQ-028 With macro DMEM_STORE_FWD_EN defined, the unit shall keep the last store's address and data; a load to that same address shall complete from this register with store latency (1 cycle) and no RAM read.
REQ-029 Without DMEM_STORE_FWD_EN, no forwarding register shall exist and every load shall take MEM_LAT+1 cycles.

Structure
REQ-030 A shared package shall hold the stackControl encodings, the FSM state enum, and DATA_W/ADDR_W defaults.
REQ-031 Immediate formation (sign-extend and upper-nibble) shall be one sub-module, imm_former.

Verification
REQ-032 Scenario: req, stackControl=0, inst=16'h0FFF -> one cycle later stackWriteData=16'hFFFF, stackWriteValid=1.
REQ-033 Scenario: store 16'hBEEF at inst[11:0]=12'h005, then load 12'h005 with MEM_LAT=3 -> load done 4 cycles after req, data 16'hBEEF.
REQ-034 Scenario: stackControl=4, getinValid held low 5 cycles then high with 16'h1234 -> busy for 6 cycles, result 16'h1234.
REQ-035 Scenario: reset asserted in RD_WAIT -> IDLE at once, all outputs 0, and no done pulse afterwards.
REQ-036 Scenario: req while busy, and stackControl=6 -> the busy request is ignored; the illegal select gives err=1, stackWriteValid=0.
REQ-037 Scenario: with DMEM_STORE_FWD_EN, store then load at the same address -> load completes in 1 cycle with the stored data.
